// File: rtl/wb_pkg.sv
// Shared types and constants for the Wishbone master bridge.
//   wb_status_e : response status code returned with every response
//   wb_state_e  : bridge sequencing states
//   wb_cmd_t    : latched command (address, write data, byte selects, write enable)
package wb_pkg;

  typedef enum logic [1:0] {
    WB_OK      = 2'b00,
    WB_ERR     = 2'b01,
    WB_RTY_EXH = 2'b10,
    WB_TIMEOUT = 2'b11
  } wb_status_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_BUS     = 2'b01,
    ST_BACKOFF = 2'b10,
    ST_RESP    = 2'b11
  } wb_state_e;

  // Classic single cycles only; the bridge never issues bursts.
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
  } wb_cmd_t;

endpackage

// File: rtl/wb_timeout_cnt.sv
// Up-counter with synchronous clear, count enable and a compare flag.
// Used for both the bus no-response timeout and the retry back-off gap.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : clear the count to zero (has priority over en)
//   en         : advance the count by one
//   limit      : count value at which expire fires
//   expire     : en is high and the count equals limit this cycle
module wb_timeout_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             expire
);

  logic [CNT_W-1:0] cnt_r;

  // Count register: cleared while load is high, advances while enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= '0;
    end else if (en) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expire = en & (cnt_r == limit);

endmodule

// File: rtl/wb_master_bridge.sv
// Wishbone classic-cycle initiator. Accepts one command at a time on a
// valid/ready interface, runs it as a single Wishbone cycle (with bounded
// retry/back-off and a no-response timeout) and returns a status-tagged
// response on a valid/ready interface.
//   wb_clk_i, wb_rst_ni              : clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o          : command handshake
//   cmd_adr_i/dat_i/sel_i/we_i       : command fields
//   rsp_valid_o/rsp_ready_i          : response handshake
//   rsp_dat_o, rsp_status_o          : read data and status (00 OK, 01 ERR, 10 RTY_EXH, 11 TIMEOUT)
//   wbm_*                            : Wishbone master port
module wb_master_bridge
  import wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int MAX_RETRY      = 3,
  parameter int RETRY_GAP      = 4,
  parameter int CNT_W          = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [31:0] cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  input  logic [3:0]  cmd_sel_i,
  input  logic        cmd_we_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic [1:0]  rsp_status_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic [2:0]  wbm_cti_o,
  output logic [1:0]  wbm_bte_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic        wbm_rty_i
);

  localparam int RC_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RC_W-1:0]  RETRY_MAX = RC_W'(MAX_RETRY);
  // The timeout counter starts at 0 on the first stb cycle, so hitting
  // TIMEOUT_CYCLES-1 means stb has been high for exactly TIMEOUT_CYCLES.
  localparam logic [CNT_W-1:0] TO_LIMIT  = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] GAP_LIMIT = (RETRY_GAP > 1) ? CNT_W'(RETRY_GAP - 1) : '0;
  localparam logic             TO_ENABLE = (TIMEOUT_CYCLES > 0);

  wb_state_e        state_r;
  wb_cmd_t          cmd_r;
  logic [RC_W-1:0]  retry_cnt_r;
  logic             cyc_r;
  logic             stb_r;
  logic             ready_r;
  logic             rsp_valid_r;
  logic [31:0]      rsp_dat_r;
  wb_status_e       rsp_status_r;

  logic             in_bus_s;
  logic             in_backoff_s;
  logic             to_expire_s;
  logic             gap_expire_s;

  assign in_bus_s     = (state_r == ST_BUS);
  assign in_backoff_s = (state_r == ST_BACKOFF);

  // Held clear outside BUS, so every (re-)entry into BUS starts from zero.
  wb_timeout_cnt #(.CNT_W(CNT_W)) u_timeout_cnt (
    .clk    (wb_clk_i),
    .rst_n  (wb_rst_ni),
    .load   (!in_bus_s),
    .en     (in_bus_s),
    .limit  (TO_LIMIT),
    .expire (to_expire_s)
  );

  // Counts the idle cycles spent in BACKOFF before the re-attempt.
  wb_timeout_cnt #(.CNT_W(CNT_W)) u_gap_cnt (
    .clk    (wb_clk_i),
    .rst_n  (wb_rst_ni),
    .load   (!in_backoff_s),
    .en     (in_backoff_s),
    .limit  (GAP_LIMIT),
    .expire (gap_expire_s)
  );

  // Bridge sequencer; all interface outputs are registered here.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_r      <= ST_IDLE;
      cmd_r        <= '0;
      retry_cnt_r  <= '0;
      cyc_r        <= 1'b0;
      stb_r        <= 1'b0;
      ready_r      <= 1'b0;
      rsp_valid_r  <= 1'b0;
      rsp_dat_r    <= 32'h0000_0000;
      rsp_status_r <= WB_OK;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid_i && ready_r) begin
            cmd_r       <= '{adr: cmd_adr_i, dat: cmd_dat_i, sel: cmd_sel_i, we: cmd_we_i};
            retry_cnt_r <= '0;
            cyc_r       <= 1'b1;
            stb_r       <= 1'b1;
            ready_r     <= 1'b0;
            state_r     <= ST_BUS;
          end else begin
            ready_r <= 1'b1;
          end
        end
        ST_BUS: begin
          // err > ack > rty > timeout
          if (wbm_err_i) begin
            cyc_r        <= 1'b0;
            stb_r        <= 1'b0;
            rsp_status_r <= WB_ERR;
            rsp_dat_r    <= 32'h0000_0000;
            rsp_valid_r  <= 1'b1;
            state_r      <= ST_RESP;
          end else if (wbm_ack_i) begin
            cyc_r        <= 1'b0;
            stb_r        <= 1'b0;
            rsp_status_r <= WB_OK;
            rsp_dat_r    <= cmd_r.we ? 32'h0000_0000 : wbm_dat_i;
            rsp_valid_r  <= 1'b1;
            state_r      <= ST_RESP;
          end else if (wbm_rty_i && (retry_cnt_r < RETRY_MAX)) begin
            cyc_r       <= 1'b0;
            stb_r       <= 1'b0;
            retry_cnt_r <= retry_cnt_r + RC_W'(1);
            state_r     <= ST_BACKOFF;
          end else if (wbm_rty_i) begin
            cyc_r        <= 1'b0;
            stb_r        <= 1'b0;
            rsp_status_r <= WB_RTY_EXH;
            rsp_dat_r    <= 32'h0000_0000;
            rsp_valid_r  <= 1'b1;
            state_r      <= ST_RESP;
          end else if (to_expire_s && TO_ENABLE) begin
            cyc_r        <= 1'b0;
            stb_r        <= 1'b0;
            rsp_status_r <= WB_TIMEOUT;
            rsp_dat_r    <= 32'h0000_0000;
            rsp_valid_r  <= 1'b1;
            state_r      <= ST_RESP;
          end else begin
            state_r <= ST_BUS;
          end
        end
        ST_BACKOFF: begin
          // Slave terminations are deliberately not looked at here.
          if (gap_expire_s) begin
            cyc_r   <= 1'b1;
            stb_r   <= 1'b1;
            state_r <= ST_BUS;
          end else begin
            state_r <= ST_BACKOFF;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_r <= 1'b0;
            ready_r     <= 1'b1;
            state_r     <= ST_IDLE;
          end else begin
            state_r <= ST_RESP;
          end
        end
        default: begin
          cyc_r       <= 1'b0;
          stb_r       <= 1'b0;
          ready_r     <= 1'b0;
          rsp_valid_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready_o  = ready_r;
  assign rsp_valid_o  = rsp_valid_r;
  assign rsp_dat_o    = rsp_dat_r;
  assign rsp_status_o = rsp_status_r;
  assign wbm_adr_o    = cmd_r.adr;
  assign wbm_dat_o    = cmd_r.dat;
  assign wbm_sel_o    = cmd_r.sel;
  assign wbm_we_o     = cmd_r.we;
  assign wbm_cyc_o    = cyc_r;
  assign wbm_stb_o    = stb_r;
  assign wbm_cti_o    = CTI_CLASSIC;
  assign wbm_bte_o    = BTE_LINEAR;

endmodule

// File: tb/tb_wb_master_bridge.sv
// Self-checking bench for wb_master_bridge: scripted slave responder,
// expected bus trace and response derived from the transaction script.
module tb_wb_master_bridge;

  localparam int TO  = 8;
  localparam int MR  = 3;
  localparam int GAP = 4;

  // final-attempt behaviour codes for the scripted slave
  localparam int F_ACK = 0, F_ERR = 1, F_ERRACK = 2, F_NONE = 3, F_RTYACK = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_dat;
  logic [1:0]  rsp_status;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
  logic [2:0]  wbm_cti_o;
  logic [1:0]  wbm_bte_o;
  logic        wbm_ack_i, wbm_err_i, wbm_rty_i;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_master_bridge #(.TIMEOUT_CYCLES(TO), .MAX_RETRY(MR), .RETRY_GAP(GAP), .CNT_W(16)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_adr_i(cmd_adr),
    .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel), .cmd_we_i(cmd_we),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat),
    .rsp_status_o(rsp_status),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
    .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o), .wbm_dat_i(wbm_dat_i),
    .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_rty_i(wbm_rty_i)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // ---------------- scripted slave ----------------
  int          sc_gen = 0;
  int          sc_n_rty = 0, sc_fin = F_NONE, sc_wait = 0;
  logic [31:0] sc_rdata = 32'h0;
  bit          sc_noise = 1'b0;
  int          r_gen = -1, r_att = 0, r_cnt = 0;

  always @(negedge clk) begin
    wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_rty_i = 1'b0;
    wbm_dat_i = $urandom;
    if (r_gen != sc_gen) begin r_gen = sc_gen; r_att = 0; r_cnt = 0; end
    if (wbm_stb_o === 1'b1) begin
      if (r_cnt == sc_wait) begin
        if (r_att < sc_n_rty) wbm_rty_i = 1'b1;
        else begin
          case (sc_fin)
            F_ACK:    wbm_ack_i = 1'b1;
            F_ERR:    wbm_err_i = 1'b1;
            F_ERRACK: begin wbm_err_i = 1'b1; wbm_ack_i = 1'b1; end
            F_RTYACK: begin wbm_rty_i = 1'b1; wbm_ack_i = 1'b1; end
            default:  ;
          endcase
        end
        if (wbm_ack_i) wbm_dat_i = sc_rdata;
      end
      r_cnt++;
    end else begin
      if (r_cnt != 0) begin r_att++; r_cnt = 0; end
      if (sc_noise && $urandom_range(3, 0) == 0)
        {wbm_ack_i, wbm_err_i, wbm_rty_i} = 3'($urandom_range(7, 1));
    end
  end

  // ---------------- one transaction: model + per-cycle compare ----------------
  task automatic run_txn(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                         input logic we, input int n_rty, input int fin, input int wt,
                         input int hold, input logic [31:0] rdata,
                         output logic [1:0] o_status, output logic [31:0] o_dat,
                         output int o_stb, output int o_att);
    bit          q[$];
    int          n_att, lastdur, guard, dur;
    logic [1:0]  e_st;
    logic [31:0] e_dat;
    logic        prev, e;
    // expected outcome straight from the retry/termination rules
    e_dat = 32'h0;
    if (n_rty > MR) begin
      n_att = MR + 1; e_st = 2'b10; lastdur = wt + 1;
    end else begin
      n_att = n_rty + 1;
      case (fin)
        F_ACK, F_RTYACK: begin e_st = 2'b00; e_dat = we ? 32'h0 : rdata; end
        F_ERR, F_ERRACK: e_st = 2'b01;
        default:         e_st = 2'b11;
      endcase
      lastdur = (fin == F_NONE) ? TO : wt + 1;
    end
    for (int a = 0; a < n_att; a++) begin
      dur = (a == n_att - 1) ? lastdur : wt + 1;
      repeat (dur) q.push_back(1'b1);
      if (a < n_att - 1) repeat (GAP) q.push_back(1'b0);
    end
    o_stb = 0; o_att = 0; o_status = 2'bxx; o_dat = 32'hx;
    sc_n_rty = n_rty; sc_fin = fin; sc_wait = wt; sc_rdata = rdata; sc_gen++;
    @(negedge clk);
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
    chk("cmd_ready_idle", 32'(cmd_ready), 32'(1));
    if (cmd_ready === 1'b1) begin
      cmd_valid = 1'b1; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel; cmd_we = we;
      @(negedge clk);
      cmd_valid = 1'b0; cmd_adr = $urandom; cmd_dat = $urandom; cmd_sel = 4'($urandom); cmd_we = ~we;
      prev = 1'b0;
      while (q.size() > 0) begin
        e = q.pop_front();
        chk("stb_trace", 32'(wbm_stb_o), 32'(e));
        chk("cyc_trace", 32'(wbm_cyc_o), 32'(e));
        chk("cmd_ready_busy", 32'(cmd_ready), 32'(0));
        chk("rsp_valid_busy", 32'(rsp_valid), 32'(0));
        chk("cti_bte", 32'({wbm_cti_o, wbm_bte_o}), 32'(0));
        if (wbm_stb_o === 1'b1) begin
          o_stb++;
          if (!prev) o_att++;
          chk("bus_adr", wbm_adr_o, adr);
          chk("bus_dat", wbm_dat_o, dat);
          chk("bus_sel", 32'(wbm_sel_o), 32'(sel));
          chk("bus_we", 32'(wbm_we_o), 32'(we));
        end
        prev = wbm_stb_o;
        @(negedge clk);
      end
      chk("rsp_valid", 32'(rsp_valid), 32'(1));
      chk("cyc_after", 32'(wbm_cyc_o), 32'(0));
      chk("rsp_status", 32'(rsp_status), 32'(e_st));
      if (e_st == 2'b00 || e_st == 2'b01) chk("rsp_dat", rsp_dat, e_dat);
      o_status = rsp_status; o_dat = rsp_dat;
      repeat (hold) begin
        @(negedge clk);
        chk("rsp_valid_hold", 32'(rsp_valid), 32'(1));
        chk("rsp_status_hold", 32'(rsp_status), 32'(o_status));
        chk("rsp_dat_hold", rsp_dat, o_dat);
        chk("cmd_ready_resp", 32'(cmd_ready), 32'(0));
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("rsp_valid_done", 32'(rsp_valid), 32'(0));
      chk("cmd_ready_done", 32'(cmd_ready), 32'(1));
    end
  endtask

  logic [1:0]  st;
  logic [31:0] dt;
  int          ns, na;

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_adr = 32'h0; cmd_dat = 32'h0; cmd_sel = 4'h0; cmd_we = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'(0));
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst_cyc_stb", 32'({wbm_cyc_o, wbm_stb_o}), 32'(0));
    chk("rst_adr", wbm_adr_o, 32'h0);
    chk("rst_rsp", 32'({rsp_status, rsp_dat}), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(cmd_ready), 32'(1));

    // directed cases with hand-computed expectations
    run_txn(32'h0000_0010, 32'h0, 4'hF, 1'b0, 0, F_ACK, 2, 0, 32'hDEAD_BEEF, st, dt, ns, na);
    chk("rd_status", 32'(st), 32'(0)); chk("rd_dat", dt, 32'hDEAD_BEEF); chk("rd_stb_len", 32'(ns), 32'(3));
    run_txn(32'h1000_0020, 32'h0000_00A5, 4'b0001, 1'b1, 0, F_ACK, 0, 1, 32'hFFFF_FFFF, st, dt, ns, na);
    chk("wr_status", 32'(st), 32'(0)); chk("wr_dat", dt, 32'h0); chk("wr_stb_len", 32'(ns), 32'(1));
    run_txn(32'h2000_0004, 32'h0, 4'hF, 1'b0, 4, F_ACK, 0, 0, 32'h1111_1111, st, dt, ns, na);
    chk("rtyx_status", 32'(st), 32'(2)); chk("rtyx_attempts", 32'(na), 32'(4));
    run_txn(32'h2000_0008, 32'h0, 4'hF, 1'b0, 2, F_ACK, 1, 0, 32'h1234_5678, st, dt, ns, na);
    chk("rty2_status", 32'(st), 32'(0)); chk("rty2_dat", dt, 32'h1234_5678); chk("rty2_attempts", 32'(na), 32'(3));
    run_txn(32'h3000_0000, 32'h0, 4'hF, 1'b0, 0, F_NONE, 0, 0, 32'h0, st, dt, ns, na);
    chk("to_status", 32'(st), 32'(3)); chk("to_stb_len", 32'(ns), 32'(8));
    run_txn(32'h3000_0010, 32'h0, 4'hF, 1'b0, 0, F_ERRACK, 1, 5, 32'hCAFE_F00D, st, dt, ns, na);
    chk("errack_status", 32'(st), 32'(1)); chk("errack_dat", dt, 32'h0);

    // reset in the middle of a bus cycle
    sc_n_rty = 0; sc_fin = F_NONE; sc_wait = 0; sc_gen++;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_adr = 32'h4000_0000; cmd_we = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("mid_stb_high", 32'(wbm_stb_o), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("async_cyc_stb", 32'({wbm_cyc_o, wbm_stb_o}), 32'(0));
    chk("async_ready", 32'(cmd_ready), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("no_rsp_after_rst", 32'({rsp_valid, wbm_cyc_o}), 32'(0));
    end
    chk("ready_after_rst", 32'(cmd_ready), 32'(1));

    // randomized traffic with out-of-cycle slave noise
    sc_noise = 1'b1;
    for (int i = 0; i < 40; i++) begin
      run_txn($urandom, $urandom, 4'($urandom), 1'($urandom), $urandom_range(5, 0),
              $urandom_range(4, 0), $urandom_range(3, 0), $urandom_range(3, 0), $urandom,
              st, dt, ns, na);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
